// File: rtl/sram_rd_arbiter.sv
// sram_rd_arbiter
//   Shares one single-ported SRAM read interface among NUM_CH read masters.
//   A round-robin arbiter grants one channel per cycle (combinational
//   grant, zero latency). A {valid, one-hot channel} tag pipeline that is
//   RD_LATENCY deep follows each issued read. When the read data comes back,
//   it is registered and steered to the owning channel with a one-hot valid.
//
// Ports
//   Clk         : clock, all logic on the rising edge
//   Rst         : asynchronous active-high reset
//   chRdEn      : per-channel read request, held until granted
//   chRdAddr    : per-channel address, channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   chRdGnt     : one-hot grant, same cycle as the winning request
//   chRdData    : registered read data, shared by all channels
//   chRdValid   : one-hot, marks the channel that owns chRdData
//   sramRdEn    : SRAM read enable
//   sramRdAddr  : SRAM read address (0 when idle)
//   sramRdData  : SRAM read data, valid RD_LATENCY cycles after sampled rdEn
module sram_rd_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic [NUM_CH-1:0]            chRdEn,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] chRdAddr,
  output logic [NUM_CH-1:0]            chRdGnt,
  output logic [DATA_WIDTH-1:0]        chRdData,
  output logic [NUM_CH-1:0]            chRdValid,
  output logic                         sramRdEn,
  output logic [ADDR_WIDTH-1:0]        sramRdAddr,
  input  logic [DATA_WIDTH-1:0]        sramRdData
);

  localparam int PTR_W = $clog2(NUM_CH);
  localparam logic [PTR_W-1:0] LAST_CH = PTR_W'(NUM_CH - 1);

  logic [PTR_W-1:0]      r_ptr;
  logic [NUM_CH-1:0]     w_gnt;
  logic [PTR_W-1:0]      w_gnt_idx;
  logic                  w_gnt_any;
  logic [ADDR_WIDTH-1:0] w_addr;

  logic [RD_LATENCY-1:0] r_tag_vld;
  logic [NUM_CH-1:0]     r_tag_ch [RD_LATENCY];

  logic [NUM_CH-1:0]     r_rd_valid;
  logic [DATA_WIDTH-1:0] r_rd_data;

  // Round-robin grant. The first pass covers channels at or above the
  // pointer, and the second pass wraps to the channels below it. Together
  // they scan upward modulo NUM_CH without a modulo operator, so NUM_CH
  // that is not a power of two never yields an out-of-range index.
  always_comb begin
    w_gnt     = '0;
    w_gnt_idx = '0;
    w_gnt_any = 1'b0;
    if (!Rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!w_gnt_any && chRdEn[i] && (PTR_W'(i) >= r_ptr)) begin
          w_gnt_any = 1'b1;
          w_gnt[i]  = 1'b1;
          w_gnt_idx = PTR_W'(i);
        end
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (!w_gnt_any && chRdEn[i] && (PTR_W'(i) < r_ptr)) begin
          w_gnt_any = 1'b1;
          w_gnt[i]  = 1'b1;
          w_gnt_idx = PTR_W'(i);
        end
      end
    end
  end

  // The grant is one-hot, so an OR-mux yields 0 when nothing is granted.
  always_comb begin
    w_addr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_gnt[i]) begin
        w_addr = w_addr | chRdAddr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_ptr <= '0;
    end else if (w_gnt_any) begin
      r_ptr <= (w_gnt_idx == LAST_CH) ? '0 : w_gnt_idx + 1'b1;
    end
  end

  // Tag pipeline: stage 0 follows the SRAM read-enable edge. It never
  // stalls, so the last stage lines up with sramRdData.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_tag_vld <= '0;
      for (int s = 0; s < RD_LATENCY; s++) begin
        r_tag_ch[s] <= '0;
      end
    end else begin
      r_tag_vld[0] <= w_gnt_any;
      r_tag_ch[0]  <= w_gnt;
      for (int s = 1; s < RD_LATENCY; s++) begin
        r_tag_vld[s] <= r_tag_vld[s-1];
        r_tag_ch[s]  <= r_tag_ch[s-1];
      end
    end
  end

  // Return stage: capture the SRAM data and steer it to its owner. The data
  // register holds between returns.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_rd_valid <= '0;
      r_rd_data  <= '0;
    end else if (r_tag_vld[RD_LATENCY-1]) begin
      r_rd_valid <= r_tag_ch[RD_LATENCY-1];
      r_rd_data  <= sramRdData;
    end else begin
      r_rd_valid <= '0;
    end
  end

  assign chRdGnt    = w_gnt;
  assign sramRdEn   = w_gnt_any;
  assign sramRdAddr = w_addr;
  assign chRdValid  = r_rd_valid;
  assign chRdData   = r_rd_data;

endmodule

// File: tb/tb_sram_rd_arbiter.sv
// Bench for sram_rd_arbiter. Four 4-channel instances with RD_LATENCY 1..4
// share one stimulus, and a 3-channel instance is driven separately. Each
// instance has its own SRAM model that returns addr[7:0] ^ 8'hB0.
module tb_sram_rd_arbiter;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  logic [3:0]  en   = '0;
  logic [39:0] addr = '0;

  logic [4:1][3:0] gnt_l;
  logic [4:1][3:0] vld_l;
  logic [4:1][7:0] data_l;
  logic [4:1]      sen_l;
  logic [4:1][9:0] saddr_l;
  logic [4:1][7:0] sdata_l;

  logic [2:0]  en3   = '0;
  logic [29:0] addr3 = '0;
  logic [2:0]  gnt3, vld3;
  logic [7:0]  data3, sdata3;
  logic        sen3;
  logic [9:0]  saddr3;

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic logic [7:0] mem_f(input logic [9:0] a);
    return a[7:0] ^ 8'hB0;
  endfunction

  for (genvar L = 1; L <= 4; L++) begin : g_lat
    logic [7:0] pipe [L];
    sram_rd_arbiter #(.NUM_CH(4), .ADDR_WIDTH(10), .DATA_WIDTH(8), .RD_LATENCY(L)) dut (
      .Clk(Clk), .Rst(Rst), .chRdEn(en), .chRdAddr(addr),
      .chRdGnt(gnt_l[L]), .chRdData(data_l[L]), .chRdValid(vld_l[L]),
      .sramRdEn(sen_l[L]), .sramRdAddr(saddr_l[L]), .sramRdData(sdata_l[L])
    );
    always @(posedge Clk) begin
      pipe[0] <= mem_f(saddr_l[L]);
      for (int s = 1; s < L; s++) pipe[s] <= pipe[s-1];
    end
    assign sdata_l[L] = pipe[L-1];
  end

  sram_rd_arbiter #(.NUM_CH(3), .ADDR_WIDTH(10), .DATA_WIDTH(8), .RD_LATENCY(1)) dut3 (
    .Clk(Clk), .Rst(Rst), .chRdEn(en3), .chRdAddr(addr3),
    .chRdGnt(gnt3), .chRdData(data3), .chRdValid(vld3),
    .sramRdEn(sen3), .sramRdAddr(saddr3), .sramRdData(sdata3)
  );
  always @(posedge Clk) sdata3 <= mem_f(saddr3);

  task automatic do_reset();
    @(negedge Clk);
    Rst = 1'b1; en = '0; en3 = '0;
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1; en = 4'hF; en3 = 3'h7;
    repeat (2) @(posedge Clk);
    @(negedge Clk); #1;
    for (int L = 1; L <= 4; L++) begin
      n_cmp++; if (gnt_l[L] !== 4'h0) begin n_fail++; $display("FAIL reset_gnt L%0d got %b want 0000", L, gnt_l[L]); end
      n_cmp++; if (sen_l[L] !== 1'b0) begin n_fail++; $display("FAIL reset_sramRdEn L%0d got %b want 0", L, sen_l[L]); end
      n_cmp++; if (vld_l[L] !== 4'h0) begin n_fail++; $display("FAIL reset_valid L%0d got %b want 0000", L, vld_l[L]); end
      n_cmp++; if (data_l[L] !== 8'h00) begin n_fail++; $display("FAIL reset_data L%0d got %h want 00", L, data_l[L]); end
    end
    n_cmp++; if (gnt3 !== 3'b000) begin n_fail++; $display("FAIL reset_gnt3 got %b want 000", gnt3); end
    Rst = 1'b0; #1;
    for (int L = 1; L <= 4; L++) begin
      n_cmp++; if (gnt_l[L] !== 4'b0001) begin n_fail++; $display("FAIL post_reset_gnt L%0d got %b want 0001", L, gnt_l[L]); end
    end
    n_cmp++; if (gnt3 !== 3'b001) begin n_fail++; $display("FAIL post_reset_gnt3 got %b want 001", gnt3); end
    en = '0; en3 = '0;
  endtask

  task automatic test_single_read();
    do_reset();
    @(negedge Clk);
    en = 4'b0100; addr = '0; addr[20 +: 10] = 10'h015; #1;
    n_cmp++; if (gnt_l[1] !== 4'b0100) begin n_fail++; $display("FAIL single_gnt got %b want 0100", gnt_l[1]); end
    n_cmp++; if (saddr_l[1] !== 10'h015) begin n_fail++; $display("FAIL single_sramaddr got %h want 015", saddr_l[1]); end
    n_cmp++; if (sen_l[1] !== 1'b1) begin n_fail++; $display("FAIL single_sramen got %b want 1", sen_l[1]); end
    @(negedge Clk);
    en = '0; #1;
    n_cmp++; if (gnt_l[1] !== 4'b0000) begin n_fail++; $display("FAIL single_idle_gnt got %b want 0000", gnt_l[1]); end
    n_cmp++; if (saddr_l[1] !== 10'h000) begin n_fail++; $display("FAIL single_idle_addr got %h want 000", saddr_l[1]); end
    n_cmp++; if (vld_l[1] !== 4'b0000) begin n_fail++; $display("FAIL single_early_valid got %b want 0000", vld_l[1]); end
    @(negedge Clk); #1;
    n_cmp++; if (vld_l[1] !== 4'b0100) begin n_fail++; $display("FAIL single_valid got %b want 0100", vld_l[1]); end
    n_cmp++; if (data_l[1] !== 8'hA5) begin n_fail++; $display("FAIL single_data got %h want a5", data_l[1]); end
    @(negedge Clk); #1;
    n_cmp++; if (vld_l[1] !== 4'b0000) begin n_fail++; $display("FAIL single_valid_drop got %b want 0000", vld_l[1]); end
    n_cmp++; if (data_l[1] !== 8'hA5) begin n_fail++; $display("FAIL single_data_hold got %h want a5", data_l[1]); end
    n_cmp++; if (vld_l[2] !== 4'b0100) begin n_fail++; $display("FAIL single_valid_L2 got %b want 0100", vld_l[2]); end
    n_cmp++; if (data_l[2] !== 8'hA5) begin n_fail++; $display("FAIL single_data_L2 got %h want a5", data_l[2]); end
  endtask

  task automatic test_round_robin();
    int cnt [4];
    logic [7:0] ed [8];
    logic [3:0] eg, ev;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      @(negedge Clk);
      en = (k < 8) ? 4'hF : 4'h0;
      // Each channel moves to its second address only after its first grant.
      for (int i = 0; i < 4; i++) addr[i*10 +: 10] = 10'(((k > i) ? 64 : 0) + i*5 + 3);
      if (k < 8) ed[k] = mem_f(10'(((k >= 4) ? 64 : 0) + (k % 4)*5 + 3));
      #1;
      eg = (k < 8) ? 4'(1 << (k % 4)) : 4'h0;
      ev = (k >= 2) ? 4'(1 << ((k - 2) % 4)) : 4'h0;
      n_cmp++; if (gnt_l[1] !== eg) begin n_fail++; $display("FAIL rr_gnt cyc%0d got %b want %b", k, gnt_l[1], eg); end
      n_cmp++; if (vld_l[1] !== ev) begin n_fail++; $display("FAIL rr_valid cyc%0d got %b want %b", k, vld_l[1], ev); end
      if (k >= 2) begin
        n_cmp++; if (data_l[1] !== ed[k-2]) begin n_fail++; $display("FAIL rr_data cyc%0d got %h want %h", k, data_l[1], ed[k-2]); end
      end
      for (int i = 0; i < 4; i++) if (vld_l[1][i] === 1'b1) cnt[i]++;
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (cnt[i] !== 2) begin n_fail++; $display("FAIL rr_pulses ch%0d got %0d want 2", i, cnt[i]); end
    end
  endtask

  task automatic test_ptr_wrap();
    @(negedge Clk);
    en = 4'b1000; #1;
    n_cmp++; if (gnt_l[1] !== 4'b1000) begin n_fail++; $display("FAIL wrap_gnt_ch3 got %b want 1000", gnt_l[1]); end
    @(negedge Clk);
    en = 4'b0101; #1;
    n_cmp++; if (gnt_l[1] !== 4'b0001) begin n_fail++; $display("FAIL wrap_gnt_ch0 got %b want 0001", gnt_l[1]); end
    @(negedge Clk);
    en = 4'b0100; #1;
    n_cmp++; if (gnt_l[1] !== 4'b0100) begin n_fail++; $display("FAIL wrap_gnt_ch2 got %b want 0100", gnt_l[1]); end
    @(negedge Clk);
    en = 4'b0000;
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_latency_sweep();
    logic [3:0] eg_a [100];
    logic [7:0] ed_a [100];
    logic [3:0] eg, ev;
    int pm, g, j;
    do_reset();
    pm = 0;
    for (int k = 0; k < 108; k++) begin
      @(negedge Clk);
      if (k < 100) begin
        en = 4'($urandom_range(1, 15));
        for (int i = 0; i < 4; i++) addr[i*10 +: 10] = 10'($urandom_range(0, 1023));
        g = -1;
        for (int s = 0; s < 4; s++) if (g < 0 && en[(pm + s) % 4]) g = (pm + s) % 4;
        eg_a[k] = 4'(1 << g);
        ed_a[k] = mem_f(addr[g*10 +: 10]);
        pm = (g + 1) % 4;
      end else begin
        en = '0;
      end
      #1;
      for (int L = 1; L <= 4; L++) begin
        eg = (k < 100) ? eg_a[k] : 4'h0;
        n_cmp++; if (gnt_l[L] !== eg) begin n_fail++; $display("FAIL sweep_gnt L%0d cyc%0d got %b want %b", L, k, gnt_l[L], eg); end
        j = k - L - 1;
        ev = (j >= 0 && j < 100) ? eg_a[j] : 4'h0;
        n_cmp++; if (vld_l[L] !== ev) begin n_fail++; $display("FAIL sweep_valid L%0d cyc%0d got %b want %b", L, k, vld_l[L], ev); end
        if (j >= 0 && j < 100) begin
          n_cmp++; if (data_l[L] !== ed_a[j]) begin n_fail++; $display("FAIL sweep_data L%0d cyc%0d got %h want %h", L, k, data_l[L], ed_a[j]); end
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    logic [3:0] ev;
    do_reset();
    addr = '0;
    addr[0 +: 10] = 10'h00A; addr[10 +: 10] = 10'h033;
    addr[20 +: 10] = 10'h044; addr[30 +: 10] = 10'h3FF;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      en = 4'(1 << k); #1;
      n_cmp++; if (gnt_l[3] !== 4'(1 << k)) begin n_fail++; $display("FAIL mid_issue_gnt cyc%0d got %b want %b", k, gnt_l[3], 4'(1 << k)); end
    end
    @(negedge Clk);
    en = '0; #1;
    n_cmp++; if (vld_l[3] !== 4'h0) begin n_fail++; $display("FAIL mid_valid cyc3 got %b want 0000", vld_l[3]); end
    Rst = 1'b1;
    @(negedge Clk);
    en = 4'b1010; #1;
    n_cmp++; if (gnt_l[3] !== 4'h0) begin n_fail++; $display("FAIL mid_gnt_in_reset got %b want 0000", gnt_l[3]); end
    n_cmp++; if (sen_l[3] !== 1'b0) begin n_fail++; $display("FAIL mid_sramen_in_reset got %b want 0", sen_l[3]); end
    n_cmp++; if (vld_l[3] !== 4'h0) begin n_fail++; $display("FAIL mid_valid_in_reset got %b want 0000", vld_l[3]); end
    @(negedge Clk);
    Rst = 1'b0; #1;
    n_cmp++; if (gnt_l[3] !== 4'b0010) begin n_fail++; $display("FAIL mid_first_gnt got %b want 0010", gnt_l[3]); end
    for (int k = 6; k < 11; k++) begin
      @(negedge Clk);
      en = '0; #1;
      ev = (k == 9) ? 4'b0010 : 4'h0;
      n_cmp++; if (vld_l[3] !== ev) begin n_fail++; $display("FAIL mid_valid cyc%0d got %b want %b", k, vld_l[3], ev); end
      if (k == 9) begin
        n_cmp++; if (data_l[3] !== 8'h83) begin n_fail++; $display("FAIL mid_data got %h want 83", data_l[3]); end
      end
    end
  endtask

  task automatic test_non_pow2();
    logic [2:0] eg, ev;
    do_reset();
    for (int i = 0; i < 3; i++) addr3[i*10 +: 10] = 10'(256 + i);
    for (int k = 0; k < 9; k++) begin
      @(negedge Clk);
      en3 = (k < 7) ? 3'b111 : 3'b000; #1;
      eg = (k < 7) ? 3'(1 << (k % 3)) : 3'b000;
      ev = (k >= 2) ? 3'(1 << ((k - 2) % 3)) : 3'b000;
      n_cmp++; if (gnt3 !== eg) begin n_fail++; $display("FAIL n3_gnt cyc%0d got %b want %b", k, gnt3, eg); end
      n_cmp++; if (vld3 !== ev) begin n_fail++; $display("FAIL n3_valid cyc%0d got %b want %b", k, vld3, ev); end
      if (k >= 2) begin
        n_cmp++; if (data3 !== (8'((k - 2) % 3) ^ 8'hB0)) begin n_fail++; $display("FAIL n3_data cyc%0d got %h want %h", k, data3, 8'((k - 2) % 3) ^ 8'hB0); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_ptr_wrap();
    test_latency_sweep();
    test_reset_midflight();
    test_non_pow2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_rd_arbiter.md
# sram_rd_arbiter

Parametrised N-channel SRAM read-port arbiter. It lets NUM_CH independent read masters share one single-ported SRAM read interface. Arbitration is round-robin, and the block tracks in-flight reads through a latency-matched tag pipeline. Each read's data is returned to the requesting channel with a per-channel valid strobe. The block sits between the channel masters (DMA/hash engines) and the SRAM macro's read port, replacing point-to-point read wiring.

## Interface
Parameters:
- NUM_CH, 4, number of requesting channels (2..16)
- ADDR_WIDTH, 10, SRAM address width
- DATA_WIDTH, 8, SRAM data width
- RD_LATENCY, 1, SRAM cycles from sampled rdEn to valid rdData (1..4)

Ports:
- Clk  input  1  single clock, all logic rising-edge
- Rst  input  1  asynchronous, active-high reset
- chRdEn  input  NUM_CH  per-channel read request, held until granted
- chRdAddr  input  NUM_CH*ADDR_WIDTH  per-channel address, channel i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- chRdGnt  output  NUM_CH  one-hot grant; request accepted when chRdEn[i] & chRdGnt[i]
- chRdData  output  DATA_WIDTH  registered read data, shared by all channels
- chRdValid  output  NUM_CH  one-hot; chRdData belongs to channel i when bit i is high
- sramRdEn  output  1  SRAM read enable
- sramRdAddr  output  ADDR_WIDTH  SRAM read address
- sramRdData  input  DATA_WIDTH  SRAM read data

## Operation
- Grant logic (combinational):
  - chRdGnt selects the first requesting channel at or after priority pointer ptr, scanning upward modulo NUM_CH.
  - At most one grant bit is set. chRdGnt is 0 when no request is active.
- SRAM drive:
  - sramRdEn = |chRdGnt.
  - sramRdAddr = the granted channel's address, and 0 when there is no grant.
- Pointer update:
  - On a cycle with a grant to channel g, ptr <= (g+1) mod NUM_CH.
  - With no grant, ptr holds.
  - ptr has width $clog2(NUM_CH), with NUM_CH not a power of two handled by explicit wrap.
- Tag pipeline:
  - RD_LATENCY stages of {valid, one-hot channel}.
  - Stage 0 loads {sramRdEn, chRdGnt} each cycle and shifts every cycle, with no stall.
- Return:
  - When the last stage is valid, chRdData <= sramRdData and chRdValid <= that stage's channel.
  - Otherwise chRdValid <= 0 and chRdData holds its last value.
- Back-to-back:
  - One read is issued per cycle, sustained, with no bubbles.
  - Return order equals issue order.
- A request dropped before it is granted is legal and has no effect.
- The address must be stable while the request is pending; the block samples it only in the grant cycle.

## Timing
- Reset values (async on Rst high):
  - ptr=0
  - all tag stages invalid
  - chRdValid=0
  - chRdData=0
  - sramRdEn and chRdGnt follow the inputs combinationally; during reset they are forced to 0.
- Grant latency: 0 cycles. chRdGnt and sramRdEn are asserted in the same cycle as chRdEn when the channel wins.
- Data latency: read accepted on edge T, so chRdValid is high during cycle T+RD_LATENCY+1.
- Simultaneous requests: the winner is determined by ptr only. A losing channel keeps chRdEn high and wins within NUM_CH-1 cycles, which is the starvation bound.
- Reset mid-operation: all in-flight reads are discarded, no chRdValid is produced for them, and ptr returns to 0. Masters must reissue.
- A new grant and a return may occur in the same cycle; they are independent.

## Test plan
- Single read: NUM_CH=4, RD_LATENCY=1. Ch2 requests addr 0x15, and the SRAM model returns 0xA5.
  - chRdGnt=4'b0100 and sramRdAddr=0x15 in the same cycle.
  - Two cycles later, chRdValid=4'b0100 and chRdData=0xA5.
- Round-robin fairness: all four channels hold chRdEn for 8 cycles.
  - Grants are 0,1,2,3,0,1,2,3.
  - Each channel receives exactly two chRdValid pulses, with data matching its addresses.
- Pointer wrap with a gap: grant ch3 alone, then ch0 and ch2 request together.
  - ch0 wins, since ptr wrapped to 0.
  - ch2 wins the next cycle.
- Latency sweep: RD_LATENCY=1..4 with 100 random back-to-back reads.
  - Every return arrives exactly RD_LATENCY+1 cycles after its grant, to the correct channel, in order.
  - There are no bubbles under continuous load.
- Reset mid-flight: RD_LATENCY=3, three reads issued, Rst asserted one cycle after the last grant.
  - chRdValid stays 0 through and after reset.
  - The first post-reset grant goes to the lowest requesting channel (ptr=0).
- Non-power-of-two NUM_CH=3: all channels request continuously.
  - Grants cycle 0,1,2,0 and no grant is issued to a nonexistent channel.
